// File: rtl/bsg_cgol_ctrl.sv
// bsg_cgol_ctrl
//
// Sequencing controller for a square array of bsg_cgol_cell instances.
// A seed board and a generation count arrive over a valid/ready handshake.
// The seed is loaded into the cells with a one-cycle update pulse. The cells
// are then stepped for the requested number of generations (saturated to
// max_game_length_p). The final board is presented over a valid/yumi
// handshake.
//
// Optional build macro: BSG_CGOL_CTRL_EARLY_EXIT_EN
//   When defined, the controller keeps a snapshot of the board from the
//   previous simulation cycle. It stops stepping early as soon as the board
//   stops changing (a still life; an all-dead board counts as one).
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   v_i            seed board and frame count valid
//   ready_o        controller can accept a new game
//   data_i         seed board, bit r*board_width_p+c is cell (r,c)
//   frames_i       generations to simulate
//   update_o       load strobe to every cell's update_i
//   update_val_o   per-cell load value (bit k to cell k)
//   en_o           step enable to every cell's en_i
//   board_cells_i  per-cell current state (bit k from cell k)
//   v_o            final board valid
//   data_o         final board
//   steps_o        generations actually executed
//   yumi_i         consumer takes the result

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2((x)))
`endif

module bsg_cgol_ctrl #(
  parameter  int board_width_p     = 8,
  parameter  int max_game_length_p = 1023,
  localparam int num_cells_lp      = board_width_p * board_width_p,
  localparam int lg_len_lp         = `BSG_SAFE_CLOG2(max_game_length_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [num_cells_lp-1:0] data_i,
  input  logic [lg_len_lp-1:0]    frames_i,
  output logic                    update_o,
  output logic [num_cells_lp-1:0] update_val_o,
  output logic                    en_o,
  input  logic [num_cells_lp-1:0] board_cells_i,
  output logic                    v_o,
  output logic [num_cells_lp-1:0] data_o,
  output logic [lg_len_lp-1:0]    steps_o,
  input  logic                    yumi_i
);

  typedef enum logic [1:0] {
    eIdle = 2'd0,
    eLoad = 2'd1,
    eSim  = 2'd2,
    eDone = 2'd3
  } state_e;

  localparam logic [lg_len_lp-1:0] max_len_lp = lg_len_lp'(max_game_length_p);

  state_e                  state_r, state_n_s;
  logic [lg_len_lp-1:0]    frames_r, frames_n_s;
  logic [lg_len_lp-1:0]    steps_r, steps_n_s;
  logic [num_cells_lp-1:0] update_val_r, update_val_n_s;
  logic [lg_len_lp-1:0]    frames_sat_s;
  logic                    ready_s, update_s, en_s, v_s;
  logic                    still_s;

  // Clamp the requested count to the largest supported game length.
  always_comb begin
    if (frames_i > max_len_lp) begin
      frames_sat_s = max_len_lp;
    end else begin
      frames_sat_s = frames_i;
    end
  end

`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
  logic [num_cells_lp-1:0] snapshot_r;

  // Capture the board every simulation cycle for still-life detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      snapshot_r <= '0;
    end else if (state_r == eSim) begin
      snapshot_r <= board_cells_i;
    end else begin
      snapshot_r <= snapshot_r;
    end
  end

  // steps_r is zero only in the first eSim cycle, before any snapshot exists.
  assign still_s = (steps_r != '0) && (board_cells_i == snapshot_r);
`else
  assign still_s = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_n_s      = state_r;
    frames_n_s     = frames_r;
    steps_n_s      = steps_r;
    update_val_n_s = update_val_r;
    ready_s        = 1'b0;
    update_s       = 1'b0;
    en_s           = 1'b0;
    v_s            = 1'b0;
    case (state_r)
      eIdle: begin
        ready_s = 1'b1;
        if (v_i) begin
          update_val_n_s = data_i;
          frames_n_s     = frames_sat_s;
          steps_n_s      = '0;
          state_n_s      = eLoad;
        end else begin
          state_n_s = eIdle;
        end
      end
      eLoad: begin
        update_s = 1'b1;
        if (frames_r != '0) begin
          state_n_s = eSim;
        end else begin
          state_n_s = eDone;
        end
      end
      eSim: begin
        if (still_s) begin
          // Board stopped changing: freeze the cells and report steps so far.
          state_n_s = eDone;
        end else begin
          en_s       = 1'b1;
          frames_n_s = frames_r - lg_len_lp'(1);
          steps_n_s  = steps_r + lg_len_lp'(1);
          if (frames_r == lg_len_lp'(1)) begin
            state_n_s = eDone;
          end else begin
            state_n_s = eSim;
          end
        end
      end
      eDone: begin
        v_s = 1'b1;
        if (yumi_i) begin
          state_n_s = eIdle;
        end else begin
          state_n_s = eDone;
        end
      end
      default: begin
        state_n_s = eIdle;
      end
    endcase
  end

  // State, counters and load-value registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= eIdle;
      frames_r     <= '0;
      steps_r      <= '0;
      update_val_r <= '0;
    end else begin
      state_r      <= state_n_s;
      frames_r     <= frames_n_s;
      steps_r      <= steps_n_s;
      update_val_r <= update_val_n_s;
    end
  end

  // Handshake and control strobes are held low for the whole reset cycle.
  assign ready_o      = ready_s  & ~reset_i;
  assign update_o     = update_s & ~reset_i;
  assign en_o         = en_s     & ~reset_i;
  assign v_o          = v_s      & ~reset_i;
  assign update_val_o = update_val_r;
  assign steps_o      = steps_r;
  // Cells are frozen in eDone, so the live board is the stable result.
  assign data_o       = board_cells_i;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
module tb_bsg_cgol_ctrl;

  localparam logic [63:0] HOR_c  = 64'h0000_0000_1C00_0000; // (3,2),(3,3),(3,4)
  localparam logic [63:0] VER_c  = 64'h0000_0008_0808_0000; // (2,3),(3,3),(4,3)
  localparam logic [63:0] BLK_c  = 64'h0000_0000_0006_0600; // (1,1),(1,2),(2,1),(2,2)
  localparam logic [63:0] GLD_c  = 64'h0000_0000_0E08_0400; // glider at offset (1,1)
  localparam logic [63:0] GLD4_c = 64'h0000_001C_1008_0000; // same glider moved (+1,+1)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       vi_a, rdy_a, upd_a, en_a, v_a, yumi_a;
  logic [1:0][63:0] din_a, uval_a, cells_a, dout_a;
  logic [1:0][9:0]  frm_a, steps_a;
  logic [2:0]       st1;

  assign steps_a[1] = {7'd0, st1};

  bsg_cgol_ctrl #(.board_width_p(8), .max_game_length_p(1023)) dut0 (
    .clk_i(clk), .reset_i(reset), .v_i(vi_a[0]), .ready_o(rdy_a[0]),
    .data_i(din_a[0]), .frames_i(frm_a[0]), .update_o(upd_a[0]),
    .update_val_o(uval_a[0]), .en_o(en_a[0]), .board_cells_i(cells_a[0]),
    .v_o(v_a[0]), .data_o(dout_a[0]), .steps_o(steps_a[0]), .yumi_i(yumi_a[0]));

  bsg_cgol_ctrl #(.board_width_p(8), .max_game_length_p(5)) dut1 (
    .clk_i(clk), .reset_i(reset), .v_i(vi_a[1]), .ready_o(rdy_a[1]),
    .data_i(din_a[1]), .frames_i(frm_a[1][2:0]), .update_o(upd_a[1]),
    .update_val_o(uval_a[1]), .en_o(en_a[1]), .board_cells_i(cells_a[1]),
    .v_o(v_a[1]), .data_o(dout_a[1]), .steps_o(st1), .yumi_i(yumi_a[1]));

  // Life rule on an 8x8 board with dead cells beyond the edges.
  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 8) &&
                (c + dc >= 0) && (c + dc < 8) && b[(r + dr) * 8 + c + dc])
              cnt++;
          end
        end
        n[r * 8 + c] = b[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  // Behavioural cell arrays (no reset, like the real cells).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (upd_a[d])     cells_a[d] <= uval_a[d];
      else if (en_a[d]) cells_a[d] <= life(cells_a[d]);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [9:0]  steps;
    int          t;
    int          off;
    int          en;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int   en_cnt[2];
  int   upd_cnt[2];
  logic [1:0] v_prev;

  // Monitor: per-cycle invariants, and a scoreboard compare on each new result.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        en_cnt[d]  = 0;
        upd_cnt[d] = 0;
        v_prev[d]  = 1'b0;
      end else begin
        chk("upd_en_exclusive", {63'd0, upd_a[d] & en_a[d]}, 64'd0);
        chk("ready_v_exclusive", {63'd0, rdy_a[d] & v_a[d]}, 64'd0);
        if (en_a[d])  en_cnt[d]++;
        if (upd_a[d]) upd_cnt[d]++;
        if (v_a[d] && !v_prev[d]) begin
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: dut%0d raised v_o with no game pending", d);
          end else begin
            chk("data_o",      dout_a[d], e.data);
            chk("steps_o",     {54'd0, steps_a[d]}, {54'd0, e.steps});
            chk("v_o_latency", 64'(cyc - e.t + 1), 64'(e.off));
            chk("en_cycles",   64'(en_cnt[d]), 64'(e.en));
            chk("upd_cycles",  64'(upd_cnt[d]), 64'd1);
          end
          en_cnt[d]  = 0;
          upd_cnt[d] = 0;
        end
        v_prev[d] = v_a[d];
      end
    end
  end

  // Offer one game; expected result goes to the scoreboard at the handshake.
  task automatic issue(input int d, input logic [63:0] seed, input logic [9:0] fr,
                       input bit push, input logic [63:0] ed, input logic [9:0] es,
                       input int off, input int en);
    exp_t e;
    int k;
    k = 0;
    while (!rdy_a[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rdy_a[d]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: dut%0d ready_o=0 expected 1", d);
    end else begin
      din_a[d] = seed;
      frm_a[d] = fr;
      vi_a[d]  = 1'b1;
      if (push) begin
        e.data = ed; e.steps = es; e.t = cyc + 1; e.off = off; e.en = en;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      @(negedge clk);
      vi_a[d] = 1'b0;
    end
  endtask

  // Wait for the result, optionally stall the consumer, then take it.
  task automatic finish_game(input int d, input int hold, input logic [63:0] ed);
    int k;
    k = 0;
    while (!v_a[d] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!v_a[d]) begin
      checks++;
      errors++;
      $display("FAIL v_o_timeout: dut%0d v_o=0 expected 1", d);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_data",  dout_a[d], ed);
        chk("hold_v",     {63'd0, v_a[d]}, 64'd1);
        chk("hold_ready", {63'd0, rdy_a[d]}, 64'd0);
      end
      yumi_a[d] = 1'b1;
      @(negedge clk);
      yumi_a[d] = 1'b0;
    end
  endtask

  initial begin
    reset  = 1'b1;
    vi_a   = '0;
    yumi_a = '0;
    din_a  = '0;
    frm_a  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {63'd0, rdy_a[0]}, 64'd0);
    chk("reset_update", {63'd0, upd_a[0]}, 64'd0);
    chk("reset_en",     {63'd0, en_a[0]},  64'd0);
    chk("reset_v",      {63'd0, v_a[0]},   64'd0);
    chk("reset_steps",  {54'd0, steps_a[0]}, 64'd0);
    chk("reset_uval",   uval_a[0], 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready0", {63'd0, rdy_a[0]}, 64'd1);
    chk("idle_ready1", {63'd0, rdy_a[1]}, 64'd1);

    // Blinker: one, two and zero generations.
    issue(0, HOR_c, 10'd1, 1'b1, VER_c, 10'd1, 3, 1);
    finish_game(0, 0, VER_c);
    issue(0, HOR_c, 10'd2, 1'b1, HOR_c, 10'd2, 4, 2);
    finish_game(0, 0, HOR_c);
    issue(0, HOR_c, 10'd0, 1'b1, HOR_c, 10'd0, 2, 0);
    finish_game(0, 0, HOR_c);

    // Block still life over 20 generations.
`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
    issue(0, BLK_c, 10'd20, 1'b1, BLK_c, 10'd1, 4, 1);
`else
    issue(0, BLK_c, 10'd20, 1'b1, BLK_c, 10'd20, 22, 20);
`endif
    finish_game(0, 0, BLK_c);

    // Saturation on the max=5 instance, with a stray v_i during simulation.
    issue(1, HOR_c, 10'd7, 1'b1, VER_c, 10'd5, 7, 5);
    @(negedge clk);
    chk("busy_ready", {63'd0, rdy_a[1]}, 64'd0);
    din_a[1] = BLK_c;
    frm_a[1] = 10'd1;
    vi_a[1]  = 1'b1;
    @(negedge clk);
    vi_a[1]  = 1'b0;
    finish_game(1, 10, VER_c);
    chk("ready_after_take", {63'd0, rdy_a[1]}, 64'd1);

    // Reset in the middle of a game, then a glider run.
    issue(1, GLD_c, 10'd5, 1'b0, 64'd0, 10'd0, 0, 0);
    @(negedge clk);
    chk("pre_reset_en", {63'd0, en_a[1]}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_en",    {63'd0, en_a[1]},  64'd0);
    chk("mid_reset_ready", {63'd0, rdy_a[1]}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {63'd0, rdy_a[1]}, 64'd1);
    issue(1, GLD_c, 10'd4, 1'b1, GLD4_c, 10'd4, 6, 4);
    finish_game(1, 0, GLD4_c);

    repeat (3) @(negedge clk);
    chk("scoreboard0_empty", 64'(q0.size()), 64'd0);
    chk("scoreboard1_empty", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bsg_cgol_ctrl.md
Name: bsg_cgol_ctrl

Overview:
Sequencing controller for a square array of bsg_cgol_cell instances. Accepts a seed board and a generation count over a valid/ready handshake, and loads the seed into the cells with a one-cycle update pulse. It then drives the cells' step enable for exactly the requested number of generations and presents the final board on a valid/yumi output handshake. It sits between the host-side interface and the cell array.

Parameters:
board_width_p, 8, board edge length; the board has board_width_p*board_width_p cells, and N below means that count
max_game_length_p, 1023, largest generation count accepted
lg_len_lp (local), `BSG_SAFE_CLOG2(max_game_length_p+1), width of the count ports

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
v_i  input  1  seed board and frame count are valid
ready_o  output  1  controller can accept a new game
data_i  input  N  seed board, bit r*board_width_p+c is cell (r,c), 1 = alive
frames_i  input  lg_len_lp  generations to simulate
update_o  output  1  to every cell's update_i
update_val_o  output  N  bit k to cell k's update_val_i
en_o  output  1  to every cell's en_i
board_cells_i  input  N  bit k from cell k's data_o
v_o  output  1  final board valid
data_o  output  N  final board
steps_o  output  lg_len_lp  generations actually executed
yumi_i  input  1  consumer takes the result

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset state: FSM in eIdle, frame counter cleared, steps counter cleared, update_val_o register cleared.
  - While reset_i is high: ready_o=0, update_o=0, en_o=0, v_o=0.
  - Reset mid-game aborts to eIdle. The cells have no reset, so board contents are don't-care until the next load.
- eIdle: ready_o=1.
  - On v_i&ready_o: latch data_i into update_val_o, latch the frame count saturated to max_game_length_p, clear steps_o, go to eLoad.
  - v_i while ready_o=0 is ignored.
- eLoad (exactly 1 cycle): update_o=1, en_o=0. Next state is eSim if the count is nonzero, otherwise eDone.
- eSim: en_o=1 every cycle, counter decrements, steps_o increments. When the counter is 1, the next state is eDone.
- eDone: en_o=0, update_o=0, v_o=1, data_o=board_cells_i (stable because the cells are frozen), steps_o held.
  - On yumi_i go to eIdle. yumi_i while v_o=0 is ignored.
- Timing for handshake at edge T with count n:
  - update_o high in cycle T+1.
  - en_o high in cycles T+2..T+1+n.
  - v_o first high in cycle T+2+n.
  - With n=0, v_o is high in T+2 and data_o equals the seed.
- update_o and en_o are never both high.
- ready_o and v_o are mutually exclusive. No new game is accepted until the result is consumed.
- steps_o equals the saturated frames count when the macro below is absent.

Optional Feature:
BSG_CGOL_CTRL_EARLY_EXIT_EN.
- Defined:
  - A snapshot register captures board_cells_i every eSim cycle.
  - In any eSim cycle after the first, if board_cells_i equals the snapshot, the board has reached a still life. en_o is forced 0 in that cycle, the FSM goes to eDone, and steps_o reports the steps executed so far.
  - An all-dead board counts as a still life.
- Undefined: no snapshot register and no comparator. The full count always runs.

Test Plan:
- Blinker (cells (3,2),(3,3),(3,4) on 8x8), frames=1 -> v_o at T+3; data_o is the vertical blinker (2,3),(3,3),(4,3); steps_o=1.
- Blinker, frames=2 -> data_o equals the seed; en_o high for exactly 2 cycles; update_o high for exactly 1 cycle.
- frames=0 -> en_o never asserts; v_o at T+2; data_o equals the seed; steps_o=0.
- frames_i above max_game_length_p (param set to 5, frames_i=7) -> en_o high 5 cycles, steps_o=5. v_i pulsed during eSim is ignored. Hold yumi_i=0 for 10 cycles -> data_o stable, ready_o=0.
- Reset asserted mid-eSim -> next cycle en_o=0, ready_o=0. After release: ready_o=1, and a new glider game with frames=4 yields the glider shifted by (+1,+1).
- Block still life ((1,1),(1,2),(2,1),(2,2)), frames=20 -> with EARLY_EXIT_EN, v_o at T+4 with steps_o=1. Without the macro, v_o at T+22 with steps_o=20. data_o equals the seed in both cases.
